// File: rtl/timer_pkg.sv
// Shared register map and bit positions for the memory-mapped timer.
// Used by the bus responder and by anything that talks to the timer.
// Offsets are relative to the 8-byte aligned register window base.
package timer_pkg;

  // Register offsets within the 8-byte window
  localparam logic [2:0] TMR_CNT_L = 3'd0;
  localparam logic [2:0] TMR_CNT_H = 3'd1;
  localparam logic [2:0] TMR_LAT_L = 3'd2;
  localparam logic [2:0] TMR_LAT_H = 3'd3;
  localparam logic [2:0] TMR_CTRL  = 3'd4;
  localparam logic [2:0] TMR_STAT  = 3'd5;
  localparam logic [2:0] TMR_PRE   = 3'd6;
  localparam logic [2:0] TMR_RSVD  = 3'd7;

  // CTRL bit positions
  localparam int CTRL_EN   = 0;
  localparam int CTRL_CONT = 1;
  localparam int CTRL_IE   = 2;

  // STAT bit positions
  localparam int STAT_IF  = 0;
  localparam int STAT_RUN = 1;

endpackage

// File: rtl/timer_core.sv
// Prescaler + 16-bit down-counter datapath with RUN and IF state.
// Latency: all state updates land on the clock edge after the strobe.
// No backpressure: load/clear strobes are single-cycle and always accepted.
module timer_core
  import timer_pkg::*;
#(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             cont_i,
  input  logic [PRE_W-1:0] pre_i,
  input  logic [15:0]      lat_i,
  input  logic             load_i,
  input  logic [15:0]      load_val_i,
  input  logic             if_clr_i,
  output logic [15:0]      cnt_o,
  output logic             run_o,
  output logic             if_o
);

  localparam logic [PRE_W-1:0] PCNT_ONE = PRE_W'(1);

  logic [PRE_W-1:0] pcnt_q, pcnt_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             if_q, if_d;
  logic             tick;
  logic             undf;

  // State registers; reset abandons any count in progress
  always_ff @(posedge clk) begin
    if (rst_i) begin
      pcnt_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      if_q   <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      if_q   <= if_d;
    end
  end

  // Next state: a counter load beats any tick in the same cycle,
  // and an underflow set beats a software IF clear
  always_comb begin
    pcnt_d = pcnt_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    if_d   = if_q;
    tick   = en_i & run_q & (pcnt_q == pre_i);
    undf   = tick & (cnt_q == 16'd0);

    if (load_i) begin
      cnt_d  = load_val_i;
      pcnt_d = '0;
      run_d  = 1'b1;
      if_d   = 1'b0;
    end else begin
      if (en_i && run_q) begin
        pcnt_d = tick ? '0 : (pcnt_q + PCNT_ONE);
      end
      if (tick) begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (cont_i) begin
          // lat_i is the registered latch, so a same-cycle LAT write is not seen
          cnt_d = lat_i;
        end else begin
          run_d = 1'b0;
        end
      end
      if (undf) begin
        if_d = 1'b1;
      end else if (if_clr_i) begin
        if_d = 1'b0;
      end
    end
  end

  assign cnt_o = cnt_q;
  assign run_o = run_q;
  assign if_o  = if_q;

endmodule

// File: rtl/timer_slave.sv
// 65C02 bus responder for an 8-register down-counter timer with level IRQ.
// Latency: RD is registered, valid one cycle after the address; IRQ lags IF by one cycle.
// Backpressure: accesses only take effect while RDY=1; otherwise the block is untouched.
module timer_slave
  import timer_pkg::*;
#(
  parameter logic [15:0] BASE  = 16'hFE00,
  parameter int          PRE_W = 8
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] AD,
  input  logic [7:0]  DO,
  input  logic        WE,
  input  logic        RDY,
  output logic [7:0]  RD,
  output logic        IRQ
);

  logic [15:0]      lat_q, lat_d;
  logic [7:0]       snap_q, snap_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [7:0]       rd_q, rd_d;
  logic             irq_q, irq_d;

  logic             sel;
  logic             wr_en;
  logic             rd_en;
  logic [2:0]       off;
  logic [7:0]       rd_mux;
  logic             load;
  logic             if_clr;
  logic [15:0]      cnt;
  logic             run;
  logic             if_flag;

  assign sel    = RDY & (AD[15:3] == BASE[15:3]);
  assign wr_en  = sel & WE;
  assign rd_en  = sel & ~WE;
  assign off    = AD[2:0];
  assign load   = wr_en & (off == TMR_CNT_H);
  assign if_clr = wr_en & (off == TMR_STAT) & DO[0];

  timer_core #(
    .PRE_W(PRE_W)
  ) u_core (
    .clk       (clk),
    .rst_i     (RST),
    .en_i      (ctrl_q[CTRL_EN]),
    .cont_i    (ctrl_q[CTRL_CONT]),
    .pre_i     (pre_q),
    .lat_i     (lat_q),
    .load_i    (load),
    .load_val_i({DO, lat_q[7:0]}),
    .if_clr_i  (if_clr),
    .cnt_o     (cnt),
    .run_o     (run),
    .if_o      (if_flag)
  );

  // Read data mux over the current (pre-edge) register contents
  always_comb begin
    rd_mux = 8'h00;
    case (off)
      TMR_CNT_L: rd_mux = cnt[7:0];
      TMR_CNT_H: rd_mux = snap_q;
      TMR_LAT_L: rd_mux = lat_q[7:0];
      TMR_LAT_H: rd_mux = lat_q[15:8];
      TMR_CTRL:  rd_mux = {5'b0, ctrl_q};
      TMR_STAT:  rd_mux = {6'b0, run, if_flag};
      TMR_PRE:   rd_mux = 8'(pre_q);
      default:   rd_mux = 8'h00;
    endcase
  end

  // Register-file writes, SNAP capture on CNT_L reads, read data and IRQ next state
  always_comb begin
    lat_d  = lat_q;
    snap_d = snap_q;
    pre_d  = pre_q;
    ctrl_d = ctrl_q;
    rd_d   = 8'h00;
    irq_d  = if_flag & ctrl_q[CTRL_IE];

    if (wr_en) begin
      case (off)
        TMR_CNT_L, TMR_LAT_L: lat_d[7:0]  = DO;
        TMR_CNT_H, TMR_LAT_H: lat_d[15:8] = DO;
        TMR_CTRL:             ctrl_d      = DO[2:0];
        TMR_PRE:              pre_d       = DO[PRE_W-1:0];
        default:              ;
      endcase
    end

    if (rd_en) begin
      rd_d = rd_mux;
      // Latching the high byte here keeps an L-then-H read pair coherent
      if (off == TMR_CNT_L) begin
        snap_d = cnt[15:8];
      end
    end
  end

  // Bus-side state registers
  always_ff @(posedge clk) begin
    if (RST) begin
      lat_q  <= '0;
      snap_q <= '0;
      pre_q  <= '0;
      ctrl_q <= '0;
      rd_q   <= '0;
      irq_q  <= 1'b0;
    end else begin
      lat_q  <= lat_d;
      snap_q <= snap_d;
      pre_q  <= pre_d;
      ctrl_q <= ctrl_d;
      rd_q   <= rd_d;
      irq_q  <= irq_d;
    end
  end

  assign RD  = rd_q;
  assign IRQ = irq_q;

endmodule

// File: tb/tb_timer_slave.sv
// Directed bench for timer_slave: a register-access vector table plus
// hand-timed sequences for counting, one-shot, snapshot, clear races and reset.
// All expected values are computed by hand from the register/counting rules.
module tb_timer_slave;
  import timer_pkg::*;

  localparam logic [15:0] BASE = 16'hFE00;

  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] AD;
  logic [7:0]  DO;
  logic        WE;
  logic        RDY;
  logic [7:0]  RD;
  logic        IRQ;

  int n_cmp = 0;
  int n_bad = 0;

  timer_slave #(
    .BASE (BASE),
    .PRE_W(8)
  ) dut (
    .clk(clk),
    .RST(RST),
    .AD (AD),
    .DO (DO),
    .WE (WE),
    .RDY(RDY),
    .RD (RD),
    .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        we;
    logic [15:0] ad;
    logic [7:0]  dat;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [15:0] addr(input logic [2:0] off);
    return {BASE[15:3], off};
  endfunction

  function automatic vec_t mk(input logic rdy, input logic we, input logic [15:0] ad,
                              input logic [7:0] dat, input logic [7:0] exp_rd);
    vec_t v;
    v.rdy = rdy; v.we = we; v.ad = ad; v.dat = dat; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // One bus cycle: drive, take the edge, sample 1 time unit later, return to idle
  task automatic cyc(input logic rdy, input logic we, input logic [15:0] ad, input logic [7:0] d);
    RDY = rdy; WE = we; AD = ad; DO = d;
    @(posedge clk);
    #1;
    RDY = 1'b0; WE = 1'b0; AD = 16'h0000; DO = 8'h00;
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    cyc(1'b1, 1'b1, addr(off), d);
  endtask

  task automatic rdc(input string nm, input logic [2:0] off, input logic [7:0] exp);
    cyc(1'b1, 1'b0, addr(off), 8'h00);
    chk(nm, RD, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic irqc(input string nm, input logic exp);
    chk(nm, {7'b0, IRQ}, {7'b0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; WE = 1'b0; RDY = 1'b0; AD = 16'h0000; DO = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    RST = 1'b0;
    chk("reset_rd", RD, 8'h00);
    irqc("reset_irq", 1'b0);

    // Register access vectors: timer never started, so all reads are static
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1'b1, 1'b0, addr(3'(i)), 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 1'b1, addr(TMR_RSVD),  8'hFF, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, addr(TMR_RSVD),  8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 1'b1, addr(TMR_LAT_L), 8'hA5, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, addr(TMR_LAT_L), 8'h00, 8'hA5));
    tbl.push_back(mk(1'b1, 1'b1, addr(TMR_LAT_H), 8'h3C, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, addr(TMR_LAT_H), 8'h00, 8'h3C));
    tbl.push_back(mk(1'b1, 1'b1, addr(TMR_CNT_L), 8'h11, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, addr(TMR_LAT_L), 8'h00, 8'h11));
    tbl.push_back(mk(1'b1, 1'b0, addr(TMR_LAT_H), 8'h00, 8'h3C));
    tbl.push_back(mk(1'b1, 1'b1, addr(TMR_CTRL),  8'hFF, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, addr(TMR_CTRL),  8'h00, 8'h07));
    tbl.push_back(mk(1'b1, 1'b1, addr(TMR_PRE),   8'h5A, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, addr(TMR_PRE),   8'h00, 8'h5A));
    tbl.push_back(mk(1'b1, 1'b0, addr(TMR_STAT),  8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, addr(TMR_CNT_L), 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, addr(TMR_CNT_H), 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, 16'hFE0A,        8'h00, 8'h00));
    tbl.push_back(mk(1'b0, 1'b0, addr(TMR_LAT_L), 8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 1'b1, 16'hFE0A,        8'h99, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, addr(TMR_LAT_L), 8'h00, 8'h11));
    tbl.push_back(mk(1'b0, 1'b1, addr(TMR_LAT_L), 8'h77, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, addr(TMR_LAT_L), 8'h00, 8'h11));
    tbl.push_back(mk(1'b1, 1'b1, addr(TMR_CTRL),  8'h00, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, addr(TMR_CTRL),  8'h00, 8'h00));

    foreach (tbl[i]) begin
      cyc(tbl[i].rdy, tbl[i].we, tbl[i].ad, tbl[i].dat);
      chk($sformatf("vec%0d_rd", i), RD, tbl[i].exp_rd);
      irqc($sformatf("vec%0d_irq", i), 1'b0);
    end

    // Continuous mode, PRE=0, LAT=3: CNT 3,2,1,0,3 and IF every 4 clocks
    wr(TMR_PRE, 8'h00);
    wr(TMR_LAT_L, 8'h03);
    wr(TMR_LAT_H, 8'h00);
    wr(TMR_CTRL, 8'h07);
    wr(TMR_CNT_H, 8'h00);
    rdc("t2_cnt3", TMR_CNT_L, 8'h03); irqc("t2_irq_a", 1'b0);
    rdc("t2_cnt2", TMR_CNT_L, 8'h02); irqc("t2_irq_b", 1'b0);
    rdc("t2_cnt1", TMR_CNT_L, 8'h01); irqc("t2_irq_c", 1'b0);
    rdc("t2_cnt0", TMR_CNT_L, 8'h00); irqc("t2_irq_d", 1'b0);
    rdc("t2_reload", TMR_CNT_L, 8'h03); irqc("t2_irq_set", 1'b1);
    rdc("t2_stat_if", TMR_STAT, 8'h03);
    wr(TMR_STAT, 8'h01); irqc("t2_irq_hold", 1'b1);
    rdc("t2_stat_clr", TMR_STAT, 8'h02); irqc("t2_irq_drop", 1'b0);
    rdc("t2_stat_if2", TMR_STAT, 8'h03); irqc("t2_irq_set2", 1'b1);

    // One-shot, PRE=2, load 0001: IF after 6 clocks, RUN drops, CNT holds 0
    wr(TMR_CTRL, 8'h00);
    wr(TMR_STAT, 8'h01);
    wr(TMR_PRE, 8'h02);
    wr(TMR_LAT_L, 8'h01);
    wr(TMR_CTRL, 8'h05);
    wr(TMR_CNT_H, 8'h00);
    for (int i = 1; i <= 6; i++) rdc($sformatf("t3_run%0d", i), TMR_STAT, 8'h02);
    irqc("t3_irq_pre", 1'b0);
    rdc("t3_done", TMR_STAT, 8'h01);
    irqc("t3_irq", 1'b1);
    rdc("t3_cnt_l", TMR_CNT_L, 8'h00);
    rdc("t3_cnt_h", TMR_CNT_H, 8'h00);
    wr(TMR_STAT, 8'h01);
    idle(10);
    rdc("t3_no_reif", TMR_STAT, 8'h00);
    irqc("t3_irq_off", 1'b0);

    // Snapshot coherence across the 0100 -> 00FF borrow
    wr(TMR_CTRL, 8'h00);
    wr(TMR_STAT, 8'h01);
    wr(TMR_PRE, 8'h00);
    wr(TMR_LAT_L, 8'h00);
    wr(TMR_CNT_H, 8'h01);
    wr(TMR_CTRL, 8'h05);
    rdc("t4_cnt_l", TMR_CNT_L, 8'h00);
    rdc("t4_cnt_h", TMR_CNT_H, 8'h01);
    rdc("t4_cnt_l2", TMR_CNT_L, 8'hFE);
    rdc("t4_cnt_h2", TMR_CNT_H, 8'h00);

    // STAT clear on the underflow cycle loses; a later clear drops IRQ one clock on
    wr(TMR_CTRL, 8'h00);
    wr(TMR_STAT, 8'h01);
    wr(TMR_LAT_L, 8'h03);
    wr(TMR_LAT_H, 8'h00);
    wr(TMR_CTRL, 8'h07);
    wr(TMR_CNT_H, 8'h00);
    idle(3);
    wr(TMR_STAT, 8'h01);
    rdc("t5_set_wins", TMR_STAT, 8'h03);
    irqc("t5_irq_on", 1'b1);
    wr(TMR_CTRL, 8'h04);
    wr(TMR_STAT, 8'h01);
    irqc("t5_irq_lag", 1'b1);
    idle(1);
    irqc("t5_irq_drop", 1'b0);
    rdc("t5_stat", TMR_STAT, 8'h02);

    // Reset mid-count with IRQ high, then RDY=0 accesses change nothing
    wr(TMR_CTRL, 8'h07);
    idle(3);
    irqc("t6_irq_pre", 1'b1);
    RST = 1'b1;
    cyc(1'b1, 1'b0, addr(TMR_LAT_L), 8'h00);
    RST = 1'b0;
    chk("t6_rst_rd", RD, 8'h00);
    irqc("t6_rst_irq", 1'b0);
    rdc("t6_stat", TMR_STAT, 8'h00);
    rdc("t6_lat", TMR_LAT_L, 8'h00);
    wr(TMR_CNT_H, 8'h12);
    cyc(1'b0, 1'b1, addr(TMR_LAT_L), 8'h77);
    cyc(1'b0, 1'b1, addr(TMR_CTRL), 8'h07);
    cyc(1'b0, 1'b0, addr(TMR_CNT_L), 8'h00);
    chk("t6_nordy_rd", RD, 8'h00);
    rdc("t6_lat_keep", TMR_LAT_L, 8'h00);
    rdc("t6_ctrl_keep", TMR_CTRL, 8'h00);
    rdc("t6_snap_keep", TMR_CNT_H, 8'h00);
    rdc("t6_cnt_l", TMR_CNT_L, 8'h00);
    rdc("t6_cnt_h", TMR_CNT_H, 8'h12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
